// File: rtl/channel_demux_buffered.sv
// ---------------------------------------------------------------------------
// channel_demux_buffered
//
// Purpose:
//   Splits one GLIP FIFO input stream into CHANN output streams. Routing is
//   controlled in-band by an escape protocol:
//     CTRL_WORD, SEL(n)        -> route subsequent data to channel n
//     CTRL_WORD, CTRL_WORD     -> literal CTRL_WORD written as data
//   Each channel has its own first-word-fall-through buffer, so one slow
//   consumer only stalls literal data aimed at its channel. Protocol words
//   are always accepted. A select word naming a channel >= CHANN is trapped
//   (sticky err_bad_channel) and the stream is discarded until the next
//   valid CTRL_WORD + select pair.
//
// Handshake semantics (input and every output channel):
//   A word moves when valid and ready are both high on a rising clock edge.
//   valid must not depend on ready. fifo_in_ready is combinational on
//   fifo_in_data and the registered full flag of the active channel.
//
// Ports:
//   clk              clock, rising edge
//   com_rst          asynchronous active-high reset
//   fifo_in_valid    input word valid
//   fifo_in_ready    input word accepted when valid & ready
//   fifo_in_data     input word [WIDTH]
//   out_valid        per-channel buffer not empty [CHANN]
//   out_ready        per-channel pop [CHANN]
//   out_data         per-channel head word, channel i at [i*WIDTH +: WIDTH]
//   active_channel   currently selected channel [8]
//   err_bad_channel  sticky out-of-range select flag
//   err_clear        synchronous clear of err_bad_channel (and drop_count)
//   dbg_state        FSM state: 0 IDLE, 1 SELECT, 2 WRITE, 3 ESCAPE, 4 DISCARD
//   drop_count       saturating count of dropped words [16]
//                    (present only with CHANNEL_DEMUX_DROP_COUNT_EN)
//
// Optional feature macro: CHANNEL_DEMUX_DROP_COUNT_EN
// ---------------------------------------------------------------------------
module channel_demux_buffered #(
    parameter int          WIDTH      = 16,
    parameter int          CHANN      = 8,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] CTRL_WORD  = 16'hc001,
    parameter logic [7:0]  SEL_PREFIX = 8'hab
) (
    input  logic                   clk,
    input  logic                   com_rst,
    input  logic                   fifo_in_valid,
    output logic                   fifo_in_ready,
    input  logic [WIDTH-1:0]       fifo_in_data,
    output logic [CHANN-1:0]       out_valid,
    input  logic [CHANN-1:0]       out_ready,
    output logic [CHANN*WIDTH-1:0] out_data,
    output logic [7:0]             active_channel,
    output logic                   err_bad_channel,
    input  logic                   err_clear,
    output logic [2:0]             dbg_state
`ifdef CHANNEL_DEMUX_DROP_COUNT_EN
    ,
    output logic [15:0]            drop_count
`endif
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CH_W = (CHANN > 1) ? $clog2(CHANN) : 1;

    localparam logic [WIDTH-1:0] CTRL_W = WIDTH'(CTRL_WORD);
    localparam logic [WIDTH-9:0] SEL_W  = (WIDTH-8)'(SEL_PREFIX);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_WRITE   = 3'd2,
        ST_ESCAPE  = 3'd3,
        ST_DISCARD = 3'd4
    } state_t;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [7:0] active_q, active_d;
    logic       err_q, err_d;

    // -----------------------------------------------------------------------
    // Input word decode
    // -----------------------------------------------------------------------
    logic       is_ctrl;
    logic       is_sel;
    logic [7:0] sel_num;
    logic       sel_ok;

    assign is_ctrl = (fifo_in_data == CTRL_W);
    assign is_sel  = (fifo_in_data[WIDTH-1:8] == SEL_W);
    assign sel_num = fifo_in_data[7:0];
    assign sel_ok  = (32'(sel_num) < CHANN);

    // -----------------------------------------------------------------------
    // Channel buffer status
    // -----------------------------------------------------------------------
    logic [CHANN-1:0] full_vec;
    logic [CHANN-1:0] empty_vec;
    logic [CH_W-1:0]  wr_ch;
    logic             full_cur;

    assign wr_ch    = active_q[CH_W-1:0];
    assign full_cur = full_vec[wr_ch];

    // -----------------------------------------------------------------------
    // Ready, transfer and next-state decode
    // -----------------------------------------------------------------------
    logic xfer;
    logic wr_en;
    logic bad_sel;
    logic drop_ev;

    // Only literal data needs buffer space; protocol words always pass so a
    // full channel can never block a re-targeting sequence.
    always_comb begin
        fifo_in_ready = 1'b1;
        case (state_q)
            ST_WRITE:  fifo_in_ready = is_ctrl  | ~full_cur;
            ST_ESCAPE: fifo_in_ready = ~is_ctrl | ~full_cur;
            default:   fifo_in_ready = 1'b1;
        endcase
    end

    assign xfer = fifo_in_valid & fifo_in_ready;

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        wr_en    = 1'b0;
        bad_sel  = 1'b0;
        drop_ev  = 1'b0;
        if (xfer) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_ctrl) state_d = ST_SELECT;
                    else         drop_ev = 1'b1;
                end
                ST_SELECT: begin
                    if (is_ctrl) begin
                        state_d = ST_SELECT;
                    end else if (is_sel) begin
                        if (sel_ok) begin
                            active_d = sel_num;
                            state_d  = ST_WRITE;
                        end else begin
                            bad_sel = 1'b1;
                            state_d = ST_DISCARD;
                        end
                    end else begin
                        drop_ev = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    if (is_ctrl) state_d = ST_ESCAPE;
                    else         wr_en   = 1'b1;
                end
                ST_ESCAPE: begin
                    if (is_ctrl) begin
                        // Doubled escape: the second CTRL_WORD is payload.
                        wr_en   = 1'b1;
                        state_d = ST_WRITE;
                    end else if (is_sel) begin
                        if (sel_ok) begin
                            active_d = sel_num;
                            state_d  = ST_WRITE;
                        end else begin
                            bad_sel = 1'b1;
                            state_d = ST_DISCARD;
                        end
                    end else begin
                        drop_ev = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_DISCARD: begin
                    if (is_ctrl) state_d = ST_SELECT;
                    else         drop_ev = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A bad select arriving with err_clear keeps the flag set.
    assign err_d = (err_q & ~err_clear) | bad_sel;

    // -----------------------------------------------------------------------
    // FSM register block
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge com_rst) begin
        if (com_rst) begin
            state_q  <= ST_IDLE;
            active_q <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            err_q    <= err_d;
        end
    end

    assign active_channel  = active_q;
    assign err_bad_channel = err_q;
    assign dbg_state       = state_q;

    // -----------------------------------------------------------------------
    // Optional drop counter
    // -----------------------------------------------------------------------
`ifdef CHANNEL_DEMUX_DROP_COUNT_EN
    logic [15:0] drop_q, drop_d;

    // Like the error flag, an event coinciding with err_clear survives it.
    always_comb begin
        drop_d = drop_q;
        if (err_clear) begin
            drop_d = drop_ev ? 16'd1 : 16'd0;
        end else if (drop_ev && (drop_q != 16'hffff)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge com_rst) begin
        if (com_rst) drop_q <= 16'd0;
        else         drop_q <= drop_d;
    end

    assign drop_count = drop_q;
`else
    logic unused_drop_ev;
    assign unused_drop_ev = drop_ev;
`endif

    // -----------------------------------------------------------------------
    // Per-channel FWFT buffers
    // -----------------------------------------------------------------------
    for (genvar i = 0; i < CHANN; i++) begin : g_chan
        logic [WIDTH-1:0] mem [FIFO_DEPTH];
        logic [AW:0]      wr_ptr_q;
        logic [AW:0]      rd_ptr_q;
        logic             we;
        logic             pop;

        // Pointers carry one extra wrap bit: equal low bits with differing
        // MSBs means full, identical pointers means empty.
        assign full_vec[i]  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        assign empty_vec[i] = (wr_ptr_q == rd_ptr_q);

        // Full is taken from registers only, so a pop in the same cycle
        // does not free space for a write until the next cycle.
        assign we  = wr_en && (32'(wr_ch) == i) && !full_vec[i];
        assign pop = out_ready[i] && !empty_vec[i];

        always_ff @(posedge clk) begin
            if (we) mem[wr_ptr_q[AW-1:0]] <= fifo_in_data;
        end

        always_ff @(posedge clk or posedge com_rst) begin
            if (com_rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (we)  wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end

        assign out_valid[i]                = !empty_vec[i];
        assign out_data[i*WIDTH +: WIDTH]  = mem[rd_ptr_q[AW-1:0]];
    end

endmodule
